rom_reader: RTL and testbench

//   Initiator side of the combinational ROM interface (addr out, data in, same cycle).
//   - On a start command, walks a burst of consecutive ROM addresses, wrapping at the top.
//   - Presents each word on a valid/ready output stream.
//   - Sits between the ROM instance and any consumer (display, UART, checker).
//   - Replaces ad-hoc address sweeping with a clocked, flow-controlled reader.

---
 rtl/rom_reader_pkg.sv | 12 +
 rtl/rom_addr_ctr.sv | 40 ++++
 rtl/rom_reader.sv | 96 +++++++++
 tb/tb_rom_reader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rom_reader_pkg.sv
// Shared state encoding and default widths for the ROM burst reader.
package rom_reader_pkg;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/rom_addr_ctr.sv
// Loadable wrapping ROM address counter with a remaining-word down-counter.
// Length is clamped to the ROM depth on load; last flags the final beat.
module rom_addr_ctr
    import rom_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W:0]   load_len,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              empty
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] rem;
    logic [ADDR_W:0] len_c;

    assign len_c = (load_len > DEPTH) ? DEPTH : load_len;
    assign empty = (load_len == '0);
    assign last  = (rem == (ADDR_W+1)'(1));

    // Address wraps naturally at the top of the ROM through truncation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            rem  <= '0;
        end else if (load) begin
            addr <= load_addr;
            rem  <= len_c;
        end else if (step) begin
            addr <= addr + 1'b1;
            rem  <= rem - 1'b1;
        end
    end
endmodule

// File: rtl/rom_reader.sv
// Clocked burst reader for a combinational ROM, presenting words on a valid/ready stream.
// Optional running checksum of transferred words when ROM_READER_CKSUM_EN is defined.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] cksum
);
    state_t state;
    logic   accept, hs, last, empty;

    assign accept = (state == ST_IDLE) && start;
    assign hs     = (state == ST_SEND) && out_valid && out_ready;

    rom_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .step      (hs && !last),
        .load_addr (start_addr),
        .load_len  (length),
        .addr      (rom_addr),
        .last      (last),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (empty) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    out_data  <= rom_data;
                    out_valid <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        if (last) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ROM_READER_CKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cksum <= '0;
        else if (accept) cksum <= '0;
        else if (hs)     cksum <= cksum + out_data;
    end
`else
    assign cksum = '0;
`endif
endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader: table of bursts plus hand-written stall/reset sequences.
module tb_rom_reader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] start_addr = '0;
    logic [3:0] length = '0;
    logic [2:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy, done;
    logic [7:0] cksum;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ROM_READER_CKSUM_EN
    localparam bit CK_ON = 1'b1;
`else
    localparam bit CK_ON = 1'b0;
`endif

    always #5 clk = ~clk;
    assign rom_data = 8'hA0 + {5'd0, rom_addr};

    rom_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
        .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .cksum(cksum)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string      tag;
        logic [2:0] sa;
        logic [3:0] len;
        int         n;
        logic [7:0] ck;
        int         poke;
        int         stall_beat;
        int         stall_len;
    } vec_t;

    // Runs one burst, sampling on negedges; cyc counts negedges after the start edge.
    task automatic burst(input vec_t v);
        int         cyc, nb, first_cyc, last_hs, done_cyc, stalled;
        bit         got_done, hsk, prev_hold;
        logic [7:0] prev_data, exp_d;
        logic [2:0] a;
        nb = 0; first_cyc = -1; last_hs = -1; done_cyc = -1; stalled = 0;
        got_done = 0; prev_hold = 0; prev_data = '0;
        start_addr = v.sa; length = v.len; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!got_done && cyc < 80) begin
            if (prev_hold) begin
                chk({v.tag, "_hold_valid"}, out_valid, 1);
                chk({v.tag, "_hold_data"}, out_data, prev_data);
            end
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (done) begin
                got_done = 1; done_cyc = cyc;
                chk({v.tag, "_busy_at_done"}, busy, 1);
                chk({v.tag, "_cksum"}, cksum, CK_ON ? v.ck : 8'h00);
            end
            a = v.sa + nb[2:0];
            exp_d = 8'hA0 + {5'd0, a};
            out_ready = 1'b1;
            if (out_valid && nb == v.stall_beat && stalled < v.stall_len) begin
                out_ready = 1'b0;
                stalled++;
                chk({v.tag, "_stall_data"}, out_data, exp_d);
            end
            hsk = out_valid && out_ready;
            if (hsk) begin
                if (nb < v.n) begin
                    chk($sformatf("%s_data%0d", v.tag, nb), out_data, exp_d);
                    chk($sformatf("%s_addr%0d", v.tag, nb), rom_addr, a);
                end
                nb++;
                last_hs = cyc;
            end
            prev_hold = out_valid && !hsk;
            prev_data = out_data;
            if (cyc == v.poke) begin
                start = 1'b1; start_addr = 3'd3; length = 4'd1;
            end else begin
                start = 1'b0;
            end
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk({v.tag, "_done_seen"}, got_done, 1);
        chk({v.tag, "_beats"}, nb, v.n);
        chk({v.tag, "_latency"}, first_cyc, (v.n > 0) ? 2 : -1);
        chk({v.tag, "_done_time"}, done_cyc, (v.n > 0) ? last_hs + 1 : 1);
        if (v.stall_len > 0) chk({v.tag, "_stall_cycles"}, stalled, v.stall_len);
        @(negedge clk);
        chk({v.tag, "_busy_after"}, busy, 0);
        chk({v.tag, "_done_after"}, done, 0);
    endtask

    vec_t vecs[10];
    vec_t rv;
    int   k;

    initial begin
        vecs[0] = '{"full8",   3'd0, 4'd8,  8, 8'h1C, -1, -1, 0};
        vecs[1] = '{"wrap4",   3'd6, 4'd4,  4, 8'h8E, -1, -1, 0};
        vecs[2] = '{"empty",   3'd2, 4'd0,  0, 8'h00, -1, -1, 0};
        vecs[3] = '{"stall",   3'd0, 4'd4,  4, 8'h86, -1,  1, 5};
        vecs[4] = '{"poke",    3'd0, 4'd8,  8, 8'h1C,  5, -1, 0};
        vecs[5] = '{"clamp12", 3'd2, 4'd12, 8, 8'h1C, -1, -1, 0};
        vecs[6] = '{"wrap8",   3'd5, 4'd8,  8, 8'h1C, -1, -1, 0};
        vecs[7] = '{"one",     3'd3, 4'd1,  1, 8'hA3, -1, -1, 0};
        vecs[8] = '{"top2",    3'd7, 4'd2,  2, 8'h47, -1, -1, 0};
        vecs[9] = '{"three",   3'd1, 4'd3,  3, 8'hE6, -1, -1, 0};

        #1;
        chk("rst_addr",  rom_addr, 0);
        chk("rst_data",  out_data, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_cksum", cksum, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) burst(vecs[i]);

        // Abort mid-burst: outputs clear without a clock edge and no done follows.
        start_addr = 3'd2; length = 4'd4; out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("abort_valid_before", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_addr",  rom_addr, 0);
        chk("abort_data",  out_data, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy",  busy, 0);
        chk("abort_done",  done, 0);
        chk("abort_cksum", cksum, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rv = '{"post_rst", 3'd1, 4'd2, 2, 8'h43, -1, -1, 0};
        burst(rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
